disp_arbiter_4511: RTL and testbench

Arbiter and sequencer for a shared 4511-style BCD-to-7-segment decoder. Sixteen requesters drive active-low request lines. Bit 15 has the highest priority, matching the cascaded 148 encoder ordering. The block grants the display to one requester, drives the 4-bit code, and sequences the decoder's LE, BI_N and LT_N pins. It also enforces a minimum display time per grant and runs a lamp test after reset.

---
 rtl/disp_arbiter_4511_if.sv | 14 +
 rtl/disp_arbiter_4511.sv | 157 +++++++++++++++
 tb/tb_disp_arbiter_4511.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/disp_arbiter_4511_if.sv
// Bundle between the 4511 display arbiter and its requesters/decoder pins.
// The arbiter uses the slave modport; requesters and the bench use master.
interface disp_arbiter_4511_if;
    logic [15:0] req_N;
    logic [15:0] gnt_N;
    logic [3:0]  code;
    logic        le;
    logic        bi_n;
    logic        lt_n;
    logic        gs_n;

    modport master (output req_N, input gnt_N, code, le, bi_n, lt_n, gs_n);
    modport slave  (input req_N, output gnt_N, code, le, bi_n, lt_n, gs_n);
endinterface

// File: rtl/disp_arbiter_4511.sv
// Arbiter/sequencer for a shared 4511 BCD-to-7-segment decoder with lamp test
// and minimum hold time. Define ROUND_ROBIN_EN for rotating priority.
module disp_arbiter_4511 #(
    parameter int HOLD_CYCLES = 8,
    parameter int LT_CYCLES   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    disp_arbiter_4511_if.slave   dsp
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = (LT_CYCLES > 0) ? $clog2(LT_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LT_LAST   = LW'((LT_CYCLES > 0) ? LT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_LAMP  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GRANT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    code_r, code_s;
    logic          le_r, le_s;
    logic          bi_n_r, bi_n_s;
    logic          lt_n_r, lt_n_s;
    logic          gs_n_r, gs_n_s;
    logic [15:0]   gnt_n_r, gnt_n_s;
    logic [HW-1:0] hold_cnt_r, hold_cnt_s;
    logic [LW-1:0] lamp_cnt_r, lamp_cnt_s;
    logic [3:0]    last_grant_r, last_grant_s;
    logic [15:0]   req_act_s;
    logic [3:0]    start_s;
    logic [3:0]    win_s;

    // Descending search from 'start' with wrap-around; first active index wins.
    function automatic logic [3:0] pick_winner(input logic [15:0] act, input logic [3:0] start);
        logic       found;
        logic [3:0] idx;
        pick_winner = 4'd0;
        found       = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = start - 4'(k);
            if (!found && act[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    assign req_act_s = ~dsp.req_N;
`ifdef ROUND_ROBIN_EN
    // The previous owner is searched last; 0 after reset degenerates to fixed priority.
    assign start_s = last_grant_r - 4'd1;
`else
    assign start_s = 4'd15;
`endif
    assign win_s = pick_winner(req_act_s, start_s);

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        code_s       = code_r;
        le_s         = le_r;
        bi_n_s       = bi_n_r;
        lt_n_s       = lt_n_r;
        gs_n_s       = gs_n_r;
        gnt_n_s      = gnt_n_r;
        hold_cnt_s   = hold_cnt_r;
        lamp_cnt_s   = lamp_cnt_r;
        last_grant_s = last_grant_r;
        case (state_r)
            ST_LAMP: begin
                if ((LT_CYCLES == 32'sd0) || (lamp_cnt_r == LT_LAST)) begin
                    lt_n_s  = 1'b1;
                    bi_n_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    lamp_cnt_s = lamp_cnt_r + LW'(1);
                end
            end
            ST_IDLE: begin
                if (|req_act_s) begin
                    code_s       = win_s;
                    gnt_n_s      = ~(16'h0001 << win_s);
                    gs_n_s       = 1'b0;
                    bi_n_s       = 1'b1;
                    last_grant_s = win_s;
                    state_s      = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                le_s       = 1'b1;
                hold_cnt_s = HOLD_LOAD;
                state_s    = ST_HOLD;
            end
            ST_HOLD: begin
                // A release is only honoured once the minimum display time has run out.
                if (hold_cnt_r != HW'(0)) begin
                    hold_cnt_s = hold_cnt_r - HW'(1);
                end else if (dsp.req_N[last_grant_r]) begin
                    gnt_n_s = 16'hFFFF;
                    gs_n_s  = 1'b1;
                    bi_n_s  = 1'b0;
                    le_s    = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_LAMP;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_LAMP;
            code_r       <= 4'd0;
            le_r         <= 1'b0;
            bi_n_r       <= 1'b1;
            lt_n_r       <= 1'b0;
            gs_n_r       <= 1'b1;
            gnt_n_r      <= 16'hFFFF;
            hold_cnt_r   <= HW'(0);
            lamp_cnt_r   <= LW'(0);
            last_grant_r <= 4'd0;
        end else begin
            state_r      <= state_s;
            code_r       <= code_s;
            le_r         <= le_s;
            bi_n_r       <= bi_n_s;
            lt_n_r       <= lt_n_s;
            gs_n_r       <= gs_n_s;
            gnt_n_r      <= gnt_n_s;
            hold_cnt_r   <= hold_cnt_s;
            lamp_cnt_r   <= lamp_cnt_s;
            last_grant_r <= last_grant_s;
        end
    end

    assign dsp.gnt_N = gnt_n_r;
    assign dsp.code  = code_r;
    assign dsp.le    = le_r;
    assign dsp.bi_n  = bi_n_r;
    assign dsp.lt_n  = lt_n_r;
    assign dsp.gs_n  = gs_n_r;

endmodule

// File: tb/tb_disp_arbiter_4511.sv
// Directed self-checking bench for disp_arbiter_4511 (HOLD_CYCLES=8, LT_CYCLES=4).
module tb_disp_arbiter_4511;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    disp_arbiter_4511_if dif ();

    disp_arbiter_4511 #(.HOLD_CYCLES(8), .LT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsp   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects a grant to 'idx' on the next edge, swaps in 'req_after', then checks
    // the 9-cycle occupancy and the release edge (req_after must drop idx).
    task automatic run_grant(input logic [3:0] idx, input logic [15:0] req_after);
        logic [15:0] g;
        g = ~(16'h0001 << idx);
        tick();
        check_val("grant_code", dif.code, idx);
        check_val("grant_gnt", dif.gnt_N, g);
        check_val("grant_gs_n", dif.gs_n, 1'b0);
        check_val("grant_le", dif.le, 1'b0);
        check_val("grant_bi_n", dif.bi_n, 1'b1);
        dif.req_N = req_after;
        tick();
        check_val("hold_le", dif.le, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_val("hold_gnt", dif.gnt_N, g);
            if (i < 7) tick();
        end
        tick();
        check_val("rel_gnt", dif.gnt_N, 16'hFFFF);
        check_val("rel_gs_n", dif.gs_n, 1'b1);
        check_val("rel_bi_n", dif.bi_n, 1'b0);
        check_val("rel_le", dif.le, 1'b0);
    endtask

    initial begin
        logic [3:0] first_w;
        logic [3:0] second_w;
        logic [3:0] rr_w;
        int         low_cnt;
        n_cmp = 0;
        n_bad = 0;
`ifdef ROUND_ROBIN_EN
        first_w  = 4'd3;
        second_w = 4'd12;
        rr_w     = 4'd3;
`else
        first_w  = 4'd12;
        second_w = 4'd3;
        rr_w     = 4'd12;
`endif
        rst_n     = 1'b0;
        dif.req_N = 16'hFFFF;
        tick();
        tick();
        check_val("rst_lt_n", dif.lt_n, 1'b0);
        check_val("rst_gnt", dif.gnt_N, 16'hFFFF);
        check_val("rst_gs_n", dif.gs_n, 1'b1);
        check_val("rst_le", dif.le, 1'b0);
        check_val("rst_code", dif.code, 4'd0);
        check_val("rst_bi_n", dif.bi_n, 1'b1);

        // Lamp test: low for 4 cycles after release.
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val("lamp_lt_n", dif.lt_n, (i < 4) ? 1'b0 : 1'b1);
        end
        check_val("idle_bi_n", dif.bi_n, 1'b0);
        check_val("idle_gnt", dif.gnt_N, 16'hFFFF);
        check_val("idle_gs_n", dif.gs_n, 1'b1);
        check_val("idle_le", dif.le, 1'b0);

        // Requester 7 held 20 cycles.
        dif.req_N = 16'hFF7F;
        tick();
        check_val("r7_code", dif.code, 4'd7);
        check_val("r7_gnt", dif.gnt_N, 16'hFF7F);
        check_val("r7_gs_n", dif.gs_n, 1'b0);
        check_val("r7_le", dif.le, 1'b0);
        tick();
        check_val("r7_le_hi", dif.le, 1'b1);
        for (int i = 0; i < 18; i++) begin
            tick();
            check_val("r7_held", dif.gnt_N, 16'hFF7F);
        end
        dif.req_N = 16'hFFFF;
        tick();
        check_val("r7_rel_gnt", dif.gnt_N, 16'hFFFF);
        check_val("r7_rel_bi_n", dif.bi_n, 1'b0);

        // Bits 12 and 3 together; loser served after one blank cycle.
        dif.req_N = 16'hEFF7;
        run_grant(first_w, ~(16'h0001 << second_w));
        run_grant(second_w, 16'hFFFF);

        // Serve 12 alone, then 12 and 3 together.
        dif.req_N = 16'hEFFF;
        run_grant(4'd12, 16'hFFFF);
        dif.req_N = 16'hEFF7;
        run_grant(rr_w, 16'hFFFF);

        // Requester 0 for two cycles: full 9-cycle grant.
        dif.req_N = 16'hFFFE;
        tick();
        check_val("r0_code", dif.code, 4'd0);
        check_val("r0_gnt", dif.gnt_N, 16'hFFFE);
        tick();
        dif.req_N = 16'hFFFF;
        low_cnt = 2;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dif.gnt_N[0] == 1'b0) low_cnt++;
            else break;
        end
        check_val("r0_occupancy", low_cnt, 9);
        check_val("r0_rel_bi_n", dif.bi_n, 1'b0);

        // Async reset mid-HOLD.
        dif.req_N = 16'hFFDF;
        tick();
        check_val("r5_gnt", dif.gnt_N, 16'hFFDF);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("arst_gnt", dif.gnt_N, 16'hFFFF);
        check_val("arst_gs_n", dif.gs_n, 1'b1);
        check_val("arst_le", dif.le, 1'b0);
        check_val("arst_lt_n", dif.lt_n, 1'b0);
        check_val("arst_code", dif.code, 4'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val("arst_lamp", dif.lt_n, (i < 4) ? 1'b0 : 1'b1);
            check_val("arst_lamp_gnt", dif.gnt_N, 16'hFFFF);
        end
        run_grant(4'd5, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
